// File: rtl/minc_pkg.sv
// Shared types and constants for the minc program loader.
package minc_pkg;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        RUN  = 3'd5
    } minc_state_e;

    localparam int          MINC_ADDR_W    = 8;
    localparam int          MINC_DATA_W    = 8;
    localparam int          PROG_DEPTH     = 1 << MINC_ADDR_W;
    localparam logic [7:0]  MINC_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/minc_loader_if.sv
// Byte stream into the loader: valid/ready handshake carrying one byte per transfer.
interface minc_loader_if #(
    parameter int DATA_W = minc_pkg::MINC_DATA_W
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;

    modport master (output rx_valid, output rx_data, input  rx_ready);
    modport slave  (input  rx_valid, input  rx_data, output rx_ready);
endinterface

// File: rtl/minc_prog_ram.sv
// Program memory: 2^ADDR_W x DATA_W, one synchronous write port, one combinational read port.
// Latency: write commits on the clock edge, read is combinational (old data during a same-address write).
// Backpressure: none, the write port is always available.
module minc_prog_ram
    import minc_pkg::*;
#(
    parameter int ADDR_W = MINC_ADDR_W,
    parameter int DATA_W = MINC_DATA_W
)(
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/minc_loader.sv
// Frame loader: SYNC, LEN, data bytes (+CSUM when MINC_LOADER_CHECKSUM_EN) into program RAM, then releases the core.
// Latency: each byte takes one accepting edge; core_nreset rises one edge after the final byte is accepted.
// Backpressure: rx_ready is low only during the single DONE cycle; rx_valid gaps simply stall.
module minc_loader
    import minc_pkg::*;
#(
    parameter int                ADDR_W    = MINC_ADDR_W,
    parameter int                DATA_W    = MINC_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(MINC_SYNC_BYTE)
)(
    input  logic              CLK,
    input  logic              nRESET,
    minc_loader_if.slave      rx,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              core_nreset,
    output logic              loading,
    output logic              load_err
);
    localparam int DEPTH = 1 << ADDR_W;

    minc_state_e       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   len_v;
    logic              accept;
    logic              is_sync;
    logic              wr_en;
    logic              last_dat;

    assign rx.rx_ready = (state != DONE);
    assign accept      = rx.rx_valid && rx.rx_ready;
    assign is_sync     = (rx.rx_data == SYNC_BYTE);
    assign loading     = (state == LEN) || (state == DATA) || (state == CSUM);
    assign wr_en       = accept && (state == DATA);
    assign last_dat    = (count == (ADDR_W+1)'(1));
    // A zero length field stands for a full memory image.
    assign len_v       = (rx.rx_data == '0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(rx.rx_data);

`ifdef MINC_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] running_sum;
    logic [DATA_W-1:0] sum_chk;
    logic              sum_ok;

    assign sum_chk = running_sum + rx.rx_data;
    assign sum_ok  = (sum_chk == '0);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            running_sum <= '0;
            load_err    <= 1'b0;
        end else if (accept) begin
            if (state == LEN) begin
                running_sum <= '0;
            end else if (state == DATA) begin
                running_sum <= sum_chk;
            end else if (state == CSUM) begin
                load_err <= !sum_ok;
            end
        end
    end
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state       <= SYNC;
            addr        <= '0;
            count       <= '0;
            core_nreset <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (accept && is_sync) begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        count <= len_v;
                        addr  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        addr  <= addr + 1'b1;
                        count <= count - 1'b1;
                        if (last_dat) begin
`ifdef MINC_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef MINC_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        state <= sum_ok ? DONE : SYNC;
                    end
                end
`endif
                DONE: begin
                    state       <= RUN;
                    core_nreset <= 1'b1;
                end
                RUN: begin
                    // Core is held in reset from the edge that accepts a new header.
                    if (accept && is_sync) begin
                        state       <= LEN;
                        core_nreset <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    minc_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (addr),
        .wdata (rx.rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule
